// File: rtl/fa_trigger_bank_pkg.sv
// Shared definitions for the trigger bank: width helper and default reset payload.
package fa_trigger_bank_pkg;

  localparam int unsigned ResetValueDefault = 0;

  // Number of bits needed to index n items (minimum 1).
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) begin
      r++;
    end
    if (r == 0) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first set request at or above pointer, wrapping.
module rr_arbiter
  import fa_trigger_bank_pkg::*;
#(
  parameter  int unsigned N = 4,
  localparam int unsigned W = clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] pointer,
  input  logic         enable,
  output logic         grant_valid,
  output logic [W-1:0] grant_idx
);

  always_comb begin
    int unsigned idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(pointer) + i) % N;
      if (enable && !grant_valid && req[idx[W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = idx[W-1:0];
      end
    end
  end

endmodule

// File: rtl/fa_trigger_bank.sv
// Bank of bus-written trigger channels drained one per cycle through a round-robin
// arbiter into a registered valid/ack output, with sticky per-channel overrun flags.
module fa_trigger_bank
  import fa_trigger_bank_pkg::*;
#(
  parameter  int unsigned             ADDR_WIDTH  = 16,
  parameter  int unsigned             DATA_WIDTH  = 16,
  parameter  int unsigned             NUM_CH      = 4,
  parameter  logic [ADDR_WIDTH-1:0]   BASE_ADDR   = ADDR_WIDTH'(10),
  parameter  logic [DATA_WIDTH-1:0]   RESET_VALUE = DATA_WIDTH'(ResetValueDefault),
  localparam int unsigned             CH_WIDTH    = clog2(NUM_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] si_addr,
  input  logic [DATA_WIDTH-1:0] si_data,
  input  logic                  si_rdy,
  output logic                  si_ack,
  output logic                  out_valid,
  output logic [CH_WIDTH-1:0]   out_ch,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ack,
  output logic [NUM_CH-1:0]     pending,
  output logic [NUM_CH-1:0]     overrun,
  input  logic [NUM_CH-1:0]     overrun_clr
);

  logic [DATA_WIDTH-1:0] data_q [NUM_CH];
  logic [NUM_CH-1:0]     pending_q, pending_d;
  logic [NUM_CH-1:0]     overrun_q, overrun_d;
  logic [CH_WIDTH-1:0]   ptr_q, ptr_d;
  logic                  out_valid_q, out_valid_d;
  logic [CH_WIDTH-1:0]   out_ch_q, out_ch_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  logic [ADDR_WIDTH:0]   addr_off;
  logic                  hit;
  logic [CH_WIDTH-1:0]   wr_idx;
  logic [NUM_CH-1:0]     wr_mask;
  logic [NUM_CH-1:0]     gnt_mask;
  logic                  slot_free;
  logic                  grant_valid;
  logic [CH_WIDTH-1:0]   grant_idx;

  // Addresses below BASE_ADDR borrow into the extra top bit and fail the range check.
  assign addr_off  = {1'b0, si_addr} - {1'b0, BASE_ADDR};
  assign hit       = si_rdy && (addr_off < (ADDR_WIDTH + 1)'(NUM_CH));
  assign wr_idx    = addr_off[CH_WIDTH-1:0];
  assign si_ack    = hit;
  assign slot_free = !out_valid_q || out_ack;

  rr_arbiter #(
    .N (NUM_CH)
  ) u_arb (
    .req         (pending_q),
    .pointer     (ptr_q),
    .enable      (slot_free),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    wr_mask  = '0;
    gnt_mask = '0;
    if (hit) begin
      wr_mask[wr_idx] = 1'b1;
    end
    if (grant_valid) begin
      gnt_mask[grant_idx] = 1'b1;
    end
    // A write racing its own grant re-arms the channel without counting as an overrun.
    pending_d = (pending_q & ~gnt_mask) | wr_mask;
    overrun_d = (overrun_q & ~overrun_clr) | (wr_mask & pending_q & ~gnt_mask);

    ptr_d = ptr_q;
    if (grant_valid) begin
      ptr_d = (grant_idx == CH_WIDTH'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
    end

    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    out_data_d  = out_data_q;
    if (slot_free) begin
      if (grant_valid) begin
        out_valid_d = 1'b1;
        out_ch_d    = grant_idx;
        out_data_d  = data_q[grant_idx];
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        data_q[k] <= RESET_VALUE;
      end
      pending_q   <= '0;
      overrun_q   <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= RESET_VALUE;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (wr_mask[k]) begin
          data_q[k] <= si_data;
        end
      end
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;
  assign pending   = pending_q;
  assign overrun   = overrun_q;

endmodule
